// File: rtl/nios_pio_pkg.sv
// Shared definitions for the PIO block: register map, edge-type codes and
// the decoded slave request.
package nios_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTRB    = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Number of post-reset cycles before edge capture is trusted.
    localparam logic [1:0] PRIME_DONE = 2'd3;

    typedef struct packed {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
    } pio_req_t;

endpackage

// File: rtl/nios_pio_sync_edge.sv
// Two-flop synchroniser for the input pins plus a third stage used to
// produce a one-cycle pulse per bit on the selected edge type.
module nios_pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pins,
    output logic [DATA_WIDTH-1:0] sync,
    output logic [DATA_WIDTH-1:0] pulse
);

    logic [DATA_WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync = s2;

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign pulse = s2 & ~s3;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign pulse = ~s2 & s3;
        end else begin : g_any
            assign pulse = s2 ^ s3;
        end
    endgenerate

endmodule

// File: rtl/nios_pio_gen.sv
// Avalon-style PIO: output register with set/clear aliases, synchronised
// input read-back, per-bit edge capture and a masked level interrupt.
module nios_pio_gen
    import nios_pio_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = '0,
    parameter int          EDGE_TYPE   = EDGE_RISING
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    pio_req_t              req;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] data_out, irq_mask, edge_cap;
    logic [DATA_WIDTH-1:0] sync, pulse, cap_clr, cap_set;
    logic [1:0]            prime_cnt;
    logic                  primed;

    assign req    = '{addr: address, wr: chipselect & ~write_n, wdata: writedata};
    assign wdata  = req.wdata[DATA_WIDTH-1:0];
    assign primed = (prime_cnt == PRIME_DONE);

    nios_pio_sync_edge #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .pins  (in_port),
        .sync  (sync),
        .pulse (pulse)
    );

    // Clear is applied before set, so a coincident edge keeps its bit.
    assign cap_clr = (req.wr && req.addr == ADDR_EDGE_CAP) ? wdata : '0;
    assign cap_set = primed ? pulse : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= RESET_VALUE[DATA_WIDTH-1:0];
            irq_mask  <= '0;
            edge_cap  <= '0;
            prime_cnt <= '0;
        end else begin
            if (!primed)
                prime_cnt <= prime_cnt + 2'd1;
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
            if (req.wr) begin
                case (req.addr)
                    ADDR_DATA:     data_out <= wdata;
                    ADDR_IRQ_MASK: irq_mask <= wdata;
                    ADDR_OUTSET:   data_out <= data_out | wdata;
                    ADDR_OUTCLEAR: data_out <= data_out & ~wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (req.addr)
            ADDR_DATA:     readdata[DATA_WIDTH-1:0] = sync;
            ADDR_OUTRB:    readdata[DATA_WIDTH-1:0] = data_out;
            ADDR_IRQ_MASK: readdata[DATA_WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[DATA_WIDTH-1:0] = edge_cap;
            default:       readdata = '0;
        endcase
    end

    assign irq      = |(edge_cap & irq_mask);
    assign out_port = data_out;

endmodule

// File: tb/tb_nios_pio_gen.sv
// Bench for nios_pio_gen: an 8-bit rising-edge instance and a 3-bit any-edge
// instance share one bus, checked against a pin-history model every cycle.
module tb_nios_pio_gen;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in8, out8;
    logic [2:0]  in3, out3;
    logic [31:0] rd8, rd3;
    logic        irq8, irq3;

    int vectors    = 0;
    int miscompares = 0;

    nios_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) u_dut8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in8),
        .out_port(out8), .readdata(rd8), .irq(irq8)
    );

    nios_pio_gen #(.DATA_WIDTH(3), .RESET_VALUE(32'h5), .EDGE_TYPE(2)) u_dut3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in3),
        .out_port(out3), .readdata(rd3), .irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, the pin value seen at each of the last three edges,
    // edges elapsed since reset, and the programmer-visible registers.
    logic [31:0] m_out [2], m_mask [2], m_cap [2];
    logic [31:0] m_hist [2][3];
    int          m_since [2];
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [31:0] msk, pin, wd, det, clr;
                msk = (d == 0) ? 32'hFF : 32'h7;
                pin = (d == 0) ? {24'd0, in8} : {29'd0, in3};
                wd  = writedata & msk;
                if (reset) begin
                    m_out[d]   = (d == 0) ? 32'hA5 : 32'h5;
                    m_mask[d]  = 0;
                    m_cap[d]   = 0;
                    m_since[d] = 0;
                    for (int j = 0; j < 3; j++) m_hist[d][j] = 0;
                end else begin
                    // compare the value two edges old against three edges old
                    if (d == 0) det = m_hist[d][1] & ~m_hist[d][2];
                    else        det = m_hist[d][1] ^ m_hist[d][2];
                    det &= msk;
                    clr = (chipselect && !write_n && address == 3'd3) ? wd : 32'd0;
                    m_cap[d] = (m_cap[d] & ~clr) | ((m_since[d] >= 3) ? det : 32'd0);
                    if (chipselect && !write_n) begin
                        case (address)
                            3'd0: m_out[d] = wd;
                            3'd2: m_mask[d] = wd;
                            3'd4: m_out[d] = m_out[d] | wd;
                            3'd5: m_out[d] = m_out[d] & ~wd;
                            default: ;
                        endcase
                    end
                    m_hist[d][2] = m_hist[d][1];
                    m_hist[d][1] = m_hist[d][0];
                    m_hist[d][0] = pin;
                    if (m_since[d] < 3) m_since[d]++;
                end
            end
            if (reset) m_valid = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input int d);
        case (address)
            3'd0:    return m_hist[d][1];
            3'd1:    return m_out[d];
            3'd2:    return m_mask[d];
            3'd3:    return m_cap[d];
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_out8", {24'd0, out8}, m_out[0]);
            chk("m_irq8", {31'd0, irq8}, {31'd0, |(m_cap[0] & m_mask[0])});
            chk("m_rd8",  rd8, exp_rd(0));
            chk("m_out3", {29'd0, out3}, m_out[1]);
            chk("m_irq3", {31'd0, irq3}, {31'd0, |(m_cap[1] & m_mask[1])});
            chk("m_rd3",  rd3, exp_rd(1));
        end
    end

    // Inputs change only 2ns after a rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        tick;
        address = a;
        @(negedge clk);
        chk(name, rd8, exp);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; in8 = '0; in3 = '0;
        tick; tick;
        @(negedge clk);
        chk("rst_out", {24'd0, out8}, 32'hA5);
        chk("rst_irq", {31'd0, irq8}, 32'd0);
        tick;
        reset = 1'b0;
        for (int a = 0; a < 8; a++)
            rd("rst_rd", a[2:0], (a == 1) ? 32'hA5 : 32'h0);

        // output register and its set/clear aliases
        wr(3'd0, 32'h0F);             @(negedge clk); chk("data_out",  {24'd0, out8}, 32'h0F);
        rd("outrb_0f", 3'd1, 32'h0F);
        wr(3'd4, 32'h1234_56F0);      @(negedge clk); chk("set_out",   {24'd0, out8}, 32'hFF);
        rd("outrb_ff", 3'd1, 32'hFF);
        wr(3'd5, 32'hABCD_EF81);      @(negedge clk); chk("clear_out", {24'd0, out8}, 32'h7E);
        rd("outrb_7e", 3'd1, 32'h7E);
        wr(3'd1, 32'h00);  rd("outrb_ro", 3'd1, 32'h7E);
        wr(3'd6, 32'hFF);  rd("addr6_ign", 3'd1, 32'h7E);
        wr(3'd7, 32'hFF);  rd("addr7_zero", 3'd7, 32'h0);

        // capture latency: pin settles before edge k, bit visible after k+2
        wr(3'd2, 32'h01);
        tick; in8 = 8'h01; address = 3'd3;
        tick; @(negedge clk); chk("lat_k0", rd8, 32'h0); chk("lat_k0_irq", {31'd0, irq8}, 32'd0);
        tick; @(negedge clk); chk("lat_k1", rd8, 32'h0); chk("lat_k1_irq", {31'd0, irq8}, 32'd0);
        tick; @(negedge clk); chk("lat_k2", rd8, 32'h1); chk("lat_k2_irq", {31'd0, irq8}, 32'd1);

        // clear colliding with a fresh rising edge keeps the bit
        tick; in8 = 8'h00;
        repeat (4) tick;
        in8 = 8'h01;
        tick; tick;
        address = 3'd3; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
        tick;
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        chk("collide_cap", rd8, 32'h1);
        chk("collide_irq", {31'd0, irq8}, 32'd1);
        wr(3'd3, 32'h01); @(negedge clk);
        chk("clear_cap", rd8, 32'h0);
        chk("clear_irq", {31'd0, irq8}, 32'd0);
        tick; in8 = 8'h00;
        repeat (4) tick;
        @(negedge clk); chk("fall_ignored", rd8, 32'h0);

        // reset wins over a coincident write; high pins do not capture
        tick;
        in8 = 8'hFF; in3 = 3'h7; reset = 1'b1;
        address = 3'd0; writedata = 32'h3C; chipselect = 1'b1; write_n = 1'b0;
        tick; tick;
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk); chk("rst_wins", {24'd0, out8}, 32'hA5);
        repeat (10) tick;
        address = 3'd3;
        @(negedge clk);
        chk("prime_cap8", rd8, 32'h0);
        chk("prime_cap3", rd3, 32'h0);
        rd("prime_data", 3'd0, 32'hFF);

        // narrow instance: any-edge, masked then unmasked
        tick; address = 3'd1;
        @(negedge clk); chk("w3_outrb", rd3, 32'h5);
        for (int i = 0; i < 6; i++) begin
            tick;
            in3 = (i % 2 == 0) ? 3'h0 : 3'h7;
        end
        repeat (4) tick;
        address = 3'd3;
        @(negedge clk);
        chk("w3_irq_masked", {31'd0, irq3}, 32'd0);
        chk("w3_upper", rd3 & ~32'h7, 32'd0);
        chk("w3_cap", rd3, 32'h7);
        wr(3'd2, 32'h7); @(negedge clk);
        chk("w3_irq_unmasked", {31'd0, irq3}, 32'd1);

        tick; tick;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
